// File: rtl/pad_ctrl.sv
// Pad controller: per-pad GPIO/alternate-function muxing, pad config registers and input synchronisation.
// Optional per-pad input glitch filter enabled by defining PAD_CTRL_FILTER_EN.
module pad_ctrl #(
    parameter int NPADS    = 36,
    parameter int CFGW     = 8,
    parameter int FILT_CYC = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    reg_req_i,
    input  logic                    reg_we_i,
    input  logic [7:0]              reg_addr_i,
    input  logic [31:0]             reg_wdata_i,
    output logic [31:0]             reg_rdata_o,
    output logic                    reg_ack_o,
    input  logic [NPADS-1:0]        gpio_o_i,
    input  logic [NPADS-1:0]        gpio_en_i,
    input  logic [NPADS-1:0]        alt_o_i,
    input  logic [NPADS-1:0]        alt_en_i,
    output logic [NPADS-1:0]        gpio_i_o,
    output logic [NPADS-1:0]        alt_i_o,
    input  logic [NPADS-1:0]        pad_din_i,
    output logic [NPADS-1:0]        pad_dout_o,
    output logic [NPADS-1:0]        pad_oen_o,
    output logic [NPADS-1:0]        pad_ie_o,
    output logic [NPADS*CFGW-1:0]   pad_cfg_o
);

    localparam int RW = CFGW + 2;

    logic                r_ack;
    logic [31:0]         r_rdata;
    logic                w_accept;
    logic [NPADS*RW-1:0] w_ctrl_flat;
    logic [RW-1:0]       w_rd_ctrl;
    logic                w_unused_wdata;

    // A request arriving during the ack cycle is ignored, so ack is always a single-cycle pulse.
    assign w_accept       = reg_req_i & ~r_ack;
    assign w_unused_wdata = ^reg_wdata_i[31:RW];

    always_comb begin
        w_rd_ctrl = '0;
        for (int i = 0; i < NPADS; i++) begin
            if (reg_addr_i == 8'(i)) begin
                w_rd_ctrl = w_ctrl_flat[i*RW +: RW];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_accept;
            r_rdata <= '0;
            if (w_accept && !reg_we_i) begin
                if (reg_addr_i == 8'(NPADS)) begin
                    r_rdata <= {24'b0, 8'(NPADS)};
                end else begin
                    r_rdata <= 32'(w_rd_ctrl);
                end
            end
        end
    end

    assign reg_ack_o   = r_ack;
    assign reg_rdata_o = r_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NPADS; gi++) begin : g_pad
            logic [RW-1:0] r_ctrl;
            logic          r_dout;
            logic          r_oen;
            logic [1:0]    r_sync;
            logic          w_sel;
            logic          w_in;

            assign w_sel = r_ctrl[0];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_ctrl <= '0;
                end else if (w_accept && reg_we_i && (reg_addr_i == 8'(gi))) begin
                    r_ctrl <= reg_wdata_i[RW-1:0];
                end
            end

            // Output path is registered, so a SEL change lands one cycle after the data it gates.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_dout <= 1'b0;
                    r_oen  <= 1'b1;
                    r_sync <= '0;
                end else begin
                    r_dout <= w_sel ? alt_o_i[gi] : gpio_o_i[gi];
                    r_oen  <= ~(w_sel ? alt_en_i[gi] : gpio_en_i[gi]);
                    r_sync <= {r_sync[0], pad_din_i[gi]};
                end
            end

`ifdef PAD_CTRL_FILTER_EN
            logic       r_filt;
            logic [3:0] r_cnt;

            // Follow the synchronised input only after it has disagreed for FILT_CYC straight cycles.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_filt <= 1'b0;
                    r_cnt  <= '0;
                end else if (r_sync[1] != r_filt) begin
                    if (r_cnt == 4'(FILT_CYC - 1)) begin
                        r_filt <= r_sync[1];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_in = r_filt;
`else
            assign w_in = r_sync[1];
`endif

            assign w_ctrl_flat[gi*RW +: RW]     = r_ctrl;
            assign pad_dout_o[gi]               = r_dout;
            assign pad_oen_o[gi]                = r_oen;
            assign pad_ie_o[gi]                 = r_oen | r_ctrl[1];
            assign pad_cfg_o[gi*CFGW +: CFGW]   = r_ctrl[RW-1:2];
            assign gpio_i_o[gi]                 = ~w_sel & w_in;
            assign alt_i_o[gi]                  = w_sel & w_in;
        end
    endgenerate

endmodule

// File: tb/tb_pad_ctrl.sv
// Self-checking bench for pad_ctrl: table-driven register/pad vectors plus directed multi-cycle sequences.
module tb_pad_ctrl;

    localparam int NPADS = 36;
    localparam int CFGW  = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  reg_req;
    logic                  reg_we;
    logic [7:0]            reg_addr;
    logic [31:0]           reg_wdata;
    logic [31:0]           reg_rdata_o;
    logic                  reg_ack_o;
    logic [NPADS-1:0]      gpio_o;
    logic [NPADS-1:0]      gpio_en;
    logic [NPADS-1:0]      alt_o;
    logic [NPADS-1:0]      alt_en;
    logic [NPADS-1:0]      gpio_i_o;
    logic [NPADS-1:0]      alt_i_o;
    logic [NPADS-1:0]      pad_din;
    logic [NPADS-1:0]      pad_dout_o;
    logic [NPADS-1:0]      pad_oen_o;
    logic [NPADS-1:0]      pad_ie_o;
    logic [NPADS*CFGW-1:0] pad_cfg_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pad_ctrl #(.NPADS(NPADS), .CFGW(CFGW), .FILT_CYC(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_req_i   (reg_req),
        .reg_we_i    (reg_we),
        .reg_addr_i  (reg_addr),
        .reg_wdata_i (reg_wdata),
        .reg_rdata_o (reg_rdata_o),
        .reg_ack_o   (reg_ack_o),
        .gpio_o_i    (gpio_o),
        .gpio_en_i   (gpio_en),
        .alt_o_i     (alt_o),
        .alt_en_i    (alt_en),
        .gpio_i_o    (gpio_i_o),
        .alt_i_o     (alt_i_o),
        .pad_din_i   (pad_din),
        .pad_dout_o  (pad_dout_o),
        .pad_oen_o   (pad_oen_o),
        .pad_ie_o    (pad_ie_o),
        .pad_cfg_o   (pad_cfg_o)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        chk_pad;
        logic        g_o;
        logic        g_en;
        logic        a_o;
        logic        a_en;
        logic        e_dout;
        logic        e_oen;
        logic        e_ie;
        logic [7:0]  e_cfg;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One complete register transaction; leaves the bench at the negedge after the post-ack edge.
    task automatic reg_access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        @(negedge clk);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        @(posedge clk);
        #1 reg_req = 1'b0;
        @(negedge clk);
        check("ack_high", 64'(reg_ack_o), 64'd1);
        rdata = reg_rdata_o;
        @(posedge clk);
        @(negedge clk);
        check("ack_low", 64'(reg_ack_o), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          p;

        //          addr    wdata          chk g_o g_en a_o a_en dout oen ie  cfg    rdata
        vecs[0] = '{8'd3,   32'h0000_0001, 1, 0,  0,   1,  1,   1,   0,  0,  8'h00, 32'h001};
        vecs[1] = '{8'd5,   32'h0000_0002, 1, 0,  1,   0,  0,   0,   0,  1,  8'h00, 32'h002};
        vecs[2] = '{8'd10,  32'h0000_03FD, 1, 1,  1,   0,  0,   0,   1,  1,  8'hFF, 32'h3FD};
        vecs[3] = '{8'd35,  32'hFFFF_FFFF, 1, 0,  1,   1,  0,   1,   1,  1,  8'hFF, 32'h3FF};
        vecs[4] = '{8'd0,   32'h0000_0054, 1, 1,  1,   0,  0,   1,   0,  0,  8'h15, 32'h054};
        vecs[5] = '{8'd36,  32'h0000_1234, 0, 0,  0,   0,  0,   0,   0,  0,  8'h00, 32'd36};
        vecs[6] = '{8'd200, 32'h0000_00FF, 0, 0,  0,   0,  0,   0,   0,  0,  8'h00, 32'h000};

        rst       = 1'b1;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        gpio_o    = '1;
        gpio_en   = '1;
        alt_o     = '1;
        alt_en    = '1;
        pad_din   = '1;

        repeat (3) @(negedge clk);
        check("rst_dout", 64'(pad_dout_o), 64'd0);
        check("rst_oen", 64'(pad_oen_o), {28'd0, {NPADS{1'b1}}});
        check("rst_ie", 64'(pad_ie_o), {28'd0, {NPADS{1'b1}}});
        check("rst_cfg", 64'(|pad_cfg_o), 64'd0);
        check("rst_gpio_i", 64'(gpio_i_o), 64'd0);
        check("rst_alt_i", 64'(alt_i_o), 64'd0);
        check("rst_ack", 64'(reg_ack_o), 64'd0);
        check("rst_rdata", 64'(reg_rdata_o), 64'd0);

        gpio_o  = '0;
        gpio_en = '0;
        alt_o   = '0;
        alt_en  = '0;
        pad_din = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_oen", 64'(pad_oen_o), {28'd0, {NPADS{1'b1}}});
        check("post_rst_ie", 64'(pad_ie_o), {28'd0, {NPADS{1'b1}}});
        check("post_rst_dout", 64'(pad_dout_o), 64'd0);
        reg_access(1'b0, 8'd0, 32'd0, rd);
        check("post_rst_rd0", 64'(rd), 64'd0);

        for (int i = 0; i < 7; i++) begin
            p = int'(vecs[i].addr);
            gpio_o  = '0;
            gpio_en = '0;
            alt_o   = '0;
            alt_en  = '0;
            if (vecs[i].chk_pad) begin
                gpio_o[p]  = vecs[i].g_o;
                gpio_en[p] = vecs[i].g_en;
                alt_o[p]   = vecs[i].a_o;
                alt_en[p]  = vecs[i].a_en;
            end
            reg_access(1'b1, vecs[i].addr, vecs[i].wdata, rd);
            if (vecs[i].chk_pad) begin
                check("vec_dout", 64'(pad_dout_o[p]), 64'(vecs[i].e_dout));
                check("vec_oen", 64'(pad_oen_o[p]), 64'(vecs[i].e_oen));
                check("vec_ie", 64'(pad_ie_o[p]), 64'(vecs[i].e_ie));
                check("vec_cfg", 64'(pad_cfg_o[p*CFGW +: CFGW]), 64'(vecs[i].e_cfg));
            end
            reg_access(1'b0, vecs[i].addr, 32'd0, rd);
            check("vec_rdata", 64'(rd), 64'(vecs[i].e_rd));
            $display("vec %0d addr=%0d wdata=0x%0h rdata=0x%0h", i, vecs[i].addr, vecs[i].wdata, rd);
        end

        // SEL and function data change together on pad 3: old SEL wins for one cycle.
        gpio_o  = '0;
        gpio_en = '0;
        alt_o   = '0;
        alt_en  = '0;
        alt_o[3]  = 1'b1;
        alt_en[3] = 1'b1;
        @(negedge clk);
        check("sel_pre_dout", 64'(pad_dout_o[3]), 64'd1);
        reg_req    = 1'b1;
        reg_we     = 1'b1;
        reg_addr   = 8'd3;
        reg_wdata  = 32'd0;
        alt_o[3]   = 1'b0;
        gpio_o[3]  = 1'b1;
        gpio_en[3] = 1'b1;
        @(posedge clk);
        #1 reg_req = 1'b0;
        @(negedge clk);
        check("sel_old_dout", 64'(pad_dout_o[3]), 64'd0);
        check("sel_old_oen", 64'(pad_oen_o[3]), 64'd0);
        @(negedge clk);
        check("sel_new_dout", 64'(pad_dout_o[3]), 64'd1);
        check("sel_new_oen", 64'(pad_oen_o[3]), 64'd0);
        $display("sel switch pad3 dout=%0d", pad_dout_o[3]);

        // Request held into the ack cycle: second write must be ignored.
        @(negedge clk);
        reg_req   = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = 8'd20;
        reg_wdata = 32'h1;
        @(posedge clk);
        #1 reg_wdata = 32'h3;
        @(negedge clk);
        check("b2b_ack1", 64'(reg_ack_o), 64'd1);
        @(posedge clk);
        #1 reg_req = 1'b0;
        @(negedge clk);
        check("b2b_ack2", 64'(reg_ack_o), 64'd0);
        reg_access(1'b0, 8'd20, 32'd0, rd);
        check("b2b_rdata", 64'(rd), 64'h1);
        $display("held request addr=20 rdata=0x%0h", rd);

`ifdef PAD_CTRL_FILTER_EN
        // Pad 0 has SEL=0: short pulse rejected, long high accepted after 2+4 cycles.
        @(negedge clk);
        pad_din[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 pad_din[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("filt_pulse", 64'(gpio_i_o[0]), 64'd0);
        end
        @(negedge clk);
        pad_din[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("filt_long", 64'(gpio_i_o[0]), (k >= 6) ? 64'd1 : 64'd0);
        end
        $display("filter pad0 gpio_i=%0d", gpio_i_o[0]);
`else
        // Pad 7 input, SEL=0: appears on gpio_i_o exactly two edges later.
        @(negedge clk);
        pad_din[7] = 1'b1;
        @(negedge clk);
        check("sync_1cyc", 64'(gpio_i_o[7]), 64'd0);
        @(negedge clk);
        check("sync_2cyc", 64'(gpio_i_o[7]), 64'd1);
        check("sync_alt0", 64'(alt_i_o[7]), 64'd0);
        reg_access(1'b1, 8'd7, 32'h1, rd);
        check("sync_sel_gpio", 64'(gpio_i_o[7]), 64'd0);
        check("sync_sel_alt", 64'(alt_i_o[7]), 64'd1);
        $display("sync pad7 gpio_i=%0d alt_i=%0d", gpio_i_o[7], alt_i_o[7]);
`endif

        // Reset right after a write is accepted: no ack, register cleared.
        @(negedge clk);
        reg_req   = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = 8'd12;
        reg_wdata = 32'h3;
        @(posedge clk);
        #1;
        reg_req = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("abort_ack1", 64'(reg_ack_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ack2", 64'(reg_ack_o), 64'd0);
        reg_access(1'b0, 8'd12, 32'd0, rd);
        check("abort_rd12", 64'(rd), 64'd0);
        reg_access(1'b0, 8'd3, 32'd0, rd);
        check("abort_rd3", 64'(rd), 64'd0);
        $display("reset abort addr=12 rdata=0x%0h", rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pad_ctrl.md
PAD_CTRL -- requirements
Module: pad_ctrl

Interface
REQ-001 SHALL have parameter NPADS, default 36, meaning the number of pads served across all padring sides.
REQ-002 SHALL have parameter CFGW, default 8, meaning the per-pad padring config width.
REQ-003 SHALL have parameter FILT_CYC, default 4, meaning the input-filter stability length in cycles (range 2..15).
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 rst_i  in  1  reset; asynchronous assert, active-high.
REQ-006 reg_req_i  in  1  register access request.
REQ-007 reg_we_i  in  1  1 = write, 0 = read.
REQ-008 reg_addr_i  in  8  word address.
REQ-009 reg_wdata_i  in  32  write data.
REQ-010 reg_rdata_o  out  32  read data, valid with ack.
REQ-011 reg_ack_o  out  1  access complete.
REQ-012 gpio_o_i / gpio_en_i  in  NPADS each  SoC GPIO data and output-enable.
REQ-013 alt_o_i / alt_en_i  in  NPADS each  alternate-function (UART, clock-out, etc.) data and enable.
REQ-014 gpio_i_o  out  NPADS  synchronised pad input to the SoC GPIO block.
REQ-015 alt_i_o  out  NPADS  synchronised pad input to alternate functions.
REQ-016 pad_din_i  in  NPADS  raw data from pads.
REQ-017 pad_dout_o / pad_oen_o / pad_ie_o  out  NPADS each  data to pad, output-enable-bar, input-enable.
REQ-018 pad_cfg_o  out  NPADS*CFGW  config, pad n at bits [n*CFGW +: CFGW].

Function
REQ-019 SHALL hold one control register per pad n at address n: bit0 SEL (1 = alternate function), bit1 IE_FORCE, bits[CFGW+1:2] CFG.
REQ-020 pad_dout_o[n] SHALL be registered (1-cycle latency) from SEL ? alt_o_i[n] : gpio_o_i[n].
REQ-021 pad_oen_o[n] SHALL be registered, equal to ~(SEL ? alt_en_i[n] : gpio_en_i[n]).
REQ-022 pad_ie_o[n] SHALL equal pad_oen_o[n] | IE_FORCE; pad_cfg_o SHALL reflect CFG combinationally from the registers.
REQ-023 pad_din_i SHALL pass through a 2-flop synchroniser; synchronised value goes to gpio_i_o[n] when SEL=0, alt_i_o[n] when SEL=1; the unselected output SHALL be 0.
REQ-024 Register access: reg_ack_o SHALL pulse exactly one cycle, the cycle after reg_req_i is sampled high; no back-to-back accept while ack is high (a request in the ack cycle is ignored).
REQ-025 Write SHALL update the register on the accept edge; new SEL/CFG take effect on the pad path the next cycle.
REQ-026 Read SHALL return the register zero-extended; address NPADS returns NPADS in [7:0]; all other addresses read 0 and writes to them are dropped with ack.
REQ-027 Simultaneous SEL change and function-data change SHALL produce output from the old SEL for that cycle, new SEL next cycle (no glitch beyond registered boundary).

Reset
REQ-028 During and after rst_i: all control registers 0, pad_dout_o 0, pad_oen_o all 1, pad_ie_o all 1, pad_cfg_o 0, gpio_i_o/alt_i_o 0, synchroniser and filter state 0, reg_ack_o 0, reg_rdata_o 0.
REQ-029 Reset asserted mid-access SHALL abort it; no ack SHALL be issued for a request accepted before reset.

Configuration
REQ-030 Macro PAD_CTRL_FILTER_EN defined: each synchronised input SHALL pass through a per-pad counter; filtered output changes only after the synchronised value differs from it for FILT_CYC consecutive cycles; any reversion clears the counter.
REQ-031 Macro undefined: no filter logic; synchronised value drives outputs directly (2-cycle input latency).

Verification
REQ-032 Reset release -> pad_oen_o all 1, pad_ie_o all 1, pad_dout_o 0, read addr 0 returns 0x0.
REQ-033 Write addr 3 = 0x1, alt_o_i[3]=1, alt_en_i[3]=1, gpio_en_i[3]=0 -> pad_dout_o[3]=1, pad_oen_o[3]=0 two cycles after request.
REQ-034 Write addr 5 = 0x2 with gpio_en_i[5]=1 -> pad_oen_o[5]=0, pad_ie_o[5]=1; read addr 5 returns 0x2; read addr NPADS returns 36.
REQ-035 pad_din_i[7] 0->1 with SEL=0, filter off -> gpio_i_o[7]=1 exactly 2 cycles later, alt_i_o[7] stays 0.
REQ-036 PAD_CTRL_FILTER_EN, FILT_CYC=4: 2-cycle pulse on pad_din_i[0] -> gpio_i_o[0] unchanged; 10-cycle high -> rises after 2+4 cycles.
REQ-037 Assert rst_i in the cycle after a write request -> no ack, register reads 0 after release.
